dmem_access: RTL and testbench
==============================

# dmem_access

Memory-stage data-access sequencer for the pipelined MIPS core. It sits directly downstream of the pipeline controller and consumes the M-stage control bits `memtoregM`, `memwriteM` and `lbM`. It converts each load or store into a request/acknowledge transaction on a variable-latency data-memory port, and freezes the whole pipeline with `stallMem` until the transaction completes. It returns word or sign-extended byte load data to the M/W pipeline register and flags misaligned or timed-out accesses.

## Interface
- `TIMEOUT`, default 255: maximum BUSY cycles without `mem_ack` before abort; only used with `DMEM_TIMEOUT_EN`.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset; low forces the reset state immediately.
- `memtoregM` in 1: M-stage instruction is a load.
- `memwriteM` in 1: M-stage instruction is a store (word only).
- `lbM` in 1: load is `lb`, a byte load with sign extension.
- `aluoutM` in 32: effective byte address.
- `writedataM` in 32: store data.
- `stallMem` out 1: freeze all pipeline registers this cycle.
- `readdataM` out 32: registered load result, aligned and extended.
- `errM` out 1: sticky access-error flag.
- `mem_req` out 1: registered bus request, held until ack.
- `mem_we` out 1: request is a write.
- `mem_addr` out 32: word address `{aluoutM[31:2],2'b00}`.
- `mem_wdata` out 32: write data.
- `mem_be` out 4: byte enables; `4'b1111` for all requests.
- `mem_ack` in 1: transaction complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read data, little-endian.

## Operation
- Access condition: `acc = memtoregM | memwriteM`.
- A write takes priority when both are set; in that case `errM` is set and a write is issued.
- Misaligned access: `acc` with `aluoutM[1:0] != 0` and not `lbM`.
  - No request is issued and `errM` is set.
  - No stall is generated and `readdataM` is unchanged.
- FSM states IDLE, BUSY, DONE:
  - IDLE: on a legal `acc`, `stallMem=1` combinationally. Next state is BUSY. `mem_req` goes to 1 and `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - BUSY: `stallMem=1`. `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` stay stable.
  - BUSY on `mem_ack`: `mem_req` goes to 0 and next state is DONE. For a load, `readdataM` captures the result.
  - DONE: `stallMem=0` so the pipeline advances one cycle. Next state is IDLE unconditionally.
- Load result:
  - Word load: `readdataM = mem_rdata`.
  - `lb`: byte lane `aluoutM[1:0]` (lane 0 = bits 7:0), sign-extended to 32 bits.
- A store leaves `readdataM` unchanged.
- `mem_ack` outside BUSY is ignored.
- `errM` is cleared only by reset.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_be=4'b1111`.
  - `readdataM=0`, `errM=0`, `stallMem=0`.
- Stall length is `2 + N` cycles, where `N` is the number of BUSY cycles before the cycle in which `mem_ack` is seen. With ack in the first BUSY cycle, the stall is 2 cycles and the next cycle (DONE) advances.
- `readdataM` is valid from the DONE cycle onward and holds until the next load completes.
- Back-to-back accesses: DONE → IDLE, then the new M-stage instruction is evaluated. Minimum is 3 cycles per access.
- Non-memory instructions pass in IDLE with zero stall.
- If reset is asserted in BUSY, `mem_req` drops asynchronously and the transaction is abandoned. Ack after reset release is ignored.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - A counter cleared on IDLE→BUSY increments each BUSY cycle without ack.
  - When the count reaches `TIMEOUT`, the FSM moves to DONE with `mem_req=0` and `errM=1`. For a load, `readdataM` is set to 0.
  - An ack arriving in the same cycle as the timeout wins.
- `DMEM_TIMEOUT_EN` undefined: no counter, and BUSY waits indefinitely.

## Test plan
- Word load at `0x100`, ack after 3 BUSY cycles with `mem_rdata=0xDEADBEEF`:
  - `mem_addr=0x100`, `mem_we=0`.
  - `stallMem` high 5 cycles.
  - `readdataM=0xDEADBEEF` in DONE.
- `lb` at `0x103` with `mem_rdata=0x80112233`, immediate ack → `readdataM=0xFFFFFF80`. At `0x101` → `0x00000022`.
- Store at `0x20` with `writedataM=0x12345678`, ack after 1 cycle:
  - `mem_we=1`, `mem_wdata=0x12345678`, `mem_be=4'hF`.
  - `readdataM` unchanged.
- Word load at `0x102` → no `mem_req`, `stallMem=0`, `errM=1` persists.
- Reset asserted while BUSY:
  - `mem_req`, `stallMem` and `errM` are 0 immediately.
  - State is IDLE.
  - A late ack causes no capture.
- With `DMEM_TIMEOUT_EN` and `TIMEOUT=4`, no ack → DONE after 4 BUSY cycles, `errM=1`, `readdataM=0`.

Source files
------------

// File: rtl/dmem_access.sv
// dmem_access: M-stage data-access sequencer for the pipelined MIPS core.
// Turns loads/stores into a req/ack transaction on a variable-latency data
// memory port, stalling the pipeline until the access completes.
// Optional feature macro: DMEM_TIMEOUT_EN aborts an access after TIMEOUT
// BUSY cycles without ack (errM set, load result forced to 0).
module dmem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memtoregM,
    input  logic        memwriteM,
    input  logic        lbM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic        stallMem,
    output logic [31:0] readdataM,
    output logic        errM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        lb_q, lb_d;
    logic [1:0]  lane_q, lane_d;
    logic        stall;

    logic acc, misal, legal;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // Select the addressed byte lane and sign-extend it for lb.
    function automatic logic [31:0] lb_extend(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        b = w[{lane, 3'b000} +: 8];
        return {{24{b[7]}}, b};
    endfunction

    assign acc   = memtoregM | memwriteM;
    assign misal = acc & (aluoutM[1:0] != 2'b00) & ~lbM;
    assign legal = acc & ~misal;

    // Next-state, bus request and stall decode.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        lb_d    = lb_q;
        lane_d  = lane_q;
        stall   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (misal) begin
                    // Misaligned word access: flag it and let the pipeline move on.
                    err_d = 1'b1;
                end else if (legal) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = memwriteM;
                    addr_d  = {aluoutM[31:2], 2'b00};
                    wdata_d = writedataM;
                    lb_d    = lbM & ~memwriteM;
                    lane_d  = aluoutM[1:0];
                    // Load and store at once is illegal; the store wins.
                    if (memtoregM & memwriteM) err_d = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) rdata_d = lb_q ? lb_extend(mem_rdata, lane_q) : mem_rdata;
`ifdef DMEM_TIMEOUT_EN
                end else if (cnt_q + 1'b1 == TO_MAX) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                // One unstalled cycle so the pipeline advances past this access.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered bus outputs; reset abandons any transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            lb_q    <= 1'b0;
            lane_q  <= 2'b00;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            lb_q    <= lb_d;
            lane_q  <= lane_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Stall is gated by reset so it drops immediately when reset asserts.
    assign stallMem  = reset & stall;
    assign readdataM = rdata_q;
    assign errM      = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = 4'b1111;

endmodule

// File: tb/tb_dmem_access.sv
// Testbench for dmem_access: directed cases plus randomized accesses checked
// against a transaction-level reference model.
module tb_dmem_access;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memtoregM, memwriteM, lbM;
    logic [31:0] aluoutM, writedataM;
    logic        stallMem, errM;
    logic [31:0] readdataM;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_rd;
    logic        exp_err;

    dmem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .memtoregM(memtoregM), .memwriteM(memwriteM), .lbM(lbM),
        .aluoutM(aluoutM), .writedataM(writedataM),
        .stallMem(stallMem), .readdataM(readdataM), .errM(errM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sign-extended byte of a little-endian word, by plain arithmetic.
    function automatic logic [31:0] byte_sx(input logic [31:0] w, input logic [1:0] lane);
        logic [31:0] b;
        b = (w >> (8 * lane)) & 32'hFF;
        if (b >= 32'd128) b = b | 32'hFFFF_FF00;
        return b;
    endfunction

    task automatic clear_inputs();
        memtoregM  = 1'b0;
        memwriteM  = 1'b0;
        lbM        = 1'b0;
        aluoutM    = 32'h0;
        writedataM = 32'h0;
    endtask

    // One M-stage instruction; memory acks after 'lat' BUSY cycles without ack.
    task automatic do_access(input logic mtr, input logic mw, input logic lb,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int lat, input logic [31:0] rd);
        logic acc, mis, legal;
        int   stalls;
        acc   = mtr | mw;
        mis   = acc && (addr % 4 != 0) && !lb;
        legal = acc && !mis;
        @(negedge clk);
        memtoregM = mtr; memwriteM = mw; lbM = lb; aluoutM = addr; writedataM = wd;
        mem_ack = 1'b0;
        #1;
        if (!legal) begin
            check("nostall", {31'b0, stallMem}, 32'd0);
            if (mis) exp_err = 1'b1;
            // Ack outside BUSY must be ignored.
            mem_ack = 1'b1; mem_rdata = $urandom;
            @(posedge clk); @(negedge clk);
            mem_ack = 1'b0;
            check("noreq", {31'b0, mem_req}, 32'd0);
            check("err_idle", {31'b0, errM}, {31'b0, exp_err});
            check("rd_hold", readdataM, exp_rd);
            clear_inputs();
            return;
        end
        stalls = stallMem ? 1 : 0;
        @(posedge clk); @(negedge clk);
        check("req", {31'b0, mem_req}, 32'd1);
        check("we", {31'b0, mem_we}, {31'b0, mw});
        check("addr", mem_addr, addr & 32'hFFFF_FFFC);
        if (mw) check("wdata", mem_wdata, wd);
        check("be", {28'b0, mem_be}, 32'hF);
        for (int k = 0; k <= lat; k++) begin
            mem_ack   = (k == lat);
            mem_rdata = (k == lat) ? rd : $urandom;
            #1;
            if (stallMem) stalls++;
            check("req_hold", {31'b0, mem_req}, 32'd1);
            @(posedge clk); @(negedge clk);
        end
        mem_ack = 1'b0;
        #1;
        if (mtr && mw) exp_err = 1'b1;
        if (mtr && !mw) exp_rd = lb ? byte_sx(rd, addr[1:0]) : rd;
        check("stall_len", stalls, 32'(lat + 2));
        check("done_nostall", {31'b0, stallMem}, 32'd0);
        check("req_drop", {31'b0, mem_req}, 32'd0);
        check("readdata", readdataM, exp_rd);
        check("err", {31'b0, errM}, {31'b0, exp_err});
        clear_inputs();
        @(posedge clk);
    endtask

    initial begin
        clear_inputs();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        exp_rd = 32'h0; exp_err = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_be", {28'b0, mem_be}, 32'hF);
        check("rst_rd", readdataM, 32'h0);
        check("rst_err", {31'b0, errM}, 32'd0);
        check("rst_stall", {31'b0, stallMem}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        do_access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        check("word_load", readdataM, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 0, 32'h80112233);
        check("lb_103", readdataM, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 0, 32'h80112233);
        check("lb_101", readdataM, 32'h00000022);
        do_access(1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 1, 32'hCAFEF00D);
        check("store_rd_kept", readdataM, 32'h00000022);
        do_access(1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 0, 32'h0);
        do_access(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 0, 32'h0);
        check("misal_err", {31'b0, errM}, 32'd1);
        do_access(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
        check("err_sticky", {31'b0, errM}, 32'd1);

        // Reset asserted while BUSY
        @(negedge clk);
        memtoregM = 1'b1; aluoutM = 32'h40;
        @(posedge clk); @(negedge clk);
        check("busy_req", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_req", {31'b0, mem_req}, 32'd0);
        check("arst_stall", {31'b0, stallMem}, 32'd0);
        check("arst_err", {31'b0, errM}, 32'd0);
        exp_rd = 32'h0; exp_err = 1'b0;
        clear_inputs();
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("late_ack_rd", readdataM, 32'h0);
        check("late_ack_stall", {31'b0, stallMem}, 32'd0);
        check("late_ack_req", {31'b0, mem_req}, 32'd0);
        do_access(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 0, 32'h01020304);

        // Randomized accesses against the model
        for (int i = 0; i < 40; i++) begin
            logic mtr, mw, lb;
            int   kind;
            kind = int'($urandom_range(0, 5));
            mtr = (kind == 0) || (kind == 1) || (kind == 4);
            mw  = (kind == 2) || (kind == 4);
            lb  = (kind == 1);
            do_access(mtr, mw, lb, $urandom, $urandom, int'($urandom_range(0, 4)), $urandom);
        end

`ifdef DMEM_TIMEOUT_EN
        begin
            int stalls;
            @(negedge clk);
            memtoregM = 1'b1; aluoutM = 32'h10; mem_ack = 1'b0;
            #1;
            stalls = 0;
            for (int i = 0; i < 20; i++) begin
                if (!stallMem) break;
                stalls++;
                @(posedge clk); @(negedge clk);
            end
            exp_err = 1'b1; exp_rd = 32'h0;
            check("to_stall_len", stalls, 32'(TO + 1));
            check("to_err", {31'b0, errM}, 32'd1);
            check("to_rd", readdataM, 32'h0);
            check("to_req", {31'b0, mem_req}, 32'd0);
            clear_inputs();
            @(posedge clk);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
